// File: rtl/scalar_arg_port_pkg.sv
// Shared types and helpers for the scalar argument port.
// Consumed by scalar_arg_port and scalar_arg_resp_fifo.
package scalar_arg_port_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_RESP_DEPTH = 2;

  // Bits needed to index n entries, never less than one.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/scalar_arg_resp_fifo.sv
// Load-response buffer: circular FIFO with wrap-around pointers.
// Head data reads as zero while empty.
module scalar_arg_resp_fifo
  import scalar_arg_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = DEFAULT_RESP_DEPTH,
  parameter int unsigned CNT_W      = ptr_width(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head_data
);

  localparam int unsigned PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  pop_en;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop_en = pop && !empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; head_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop_en && full));

endmodule

// File: rtl/scalar_arg_port.sv
// Scalar kernel-argument initiator: dataflow load/store/end to single-port memory.
// Define SCALAR_ARG_PORT_STATS_EN to build the per-transaction ld_cnt/st_cnt counters.
module scalar_arg_port
  import scalar_arg_port_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RESP_DEPTH = DEFAULT_RESP_DEPTH,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  output logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_data_valid,
  input  logic                  ld_data_ready,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic                  end_valid,
  output logic                  end_ready,
  output logic                  ce0,
  output logic                  we0,
  output logic [DATA_WIDTH-1:0] mem_din0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  ld_cnt,
  output logic [CNT_WIDTH-1:0]  st_cnt
);

  localparam int unsigned CW = ptr_width(RESP_DEPTH + 1);
  localparam int unsigned OW = ptr_width(RESP_DEPTH + 2);

  state_e        state;
  logic          rd_pending;
  logic [CW-1:0] buf_count;
  logic [OW-1:0] occupancy;
  logic          st_fire;
  logic          ld_fire;
  logic          buf_pop;

  // In-flight read reserves a slot so the buffer can never overflow.
  assign occupancy = OW'(buf_count) + OW'(rd_pending);

  assign st_ready = !rst && (state == RUN);
  assign ld_ready = !rst && (state == RUN) && !st_valid && (occupancy < OW'(RESP_DEPTH));
  assign st_fire  = st_valid && st_ready;
  assign ld_fire  = ld_valid && ld_ready;

  assign ce0      = st_fire || ld_fire;
  assign we0      = st_fire;
  assign mem_din0 = st_fire ? st_data : '0;

  assign ld_data_valid = (buf_count != '0);
  assign buf_pop       = ld_data_valid && ld_data_ready;

  scalar_arg_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH),
    .CNT_W      (CW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pending),
    .push_data (mem_dout0),
    .pop       (buf_pop),
    .count     (buf_count),
    .head_data (ld_data)
  );

  // Transaction FSM; done/end_ready are registered copies of state==DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      rd_pending <= 1'b0;
      done       <= 1'b0;
      end_ready  <= 1'b0;
    end else begin
      rd_pending <= ld_fire;
      done       <= 1'b0;
      end_ready  <= 1'b0;
      case (state)
        RUN: begin
          if (end_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (!rd_pending && (buf_count == '0)) begin
            state     <= DONE;
            done      <= 1'b1;
            end_ready <= 1'b1;
          end
        end
        DONE: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef SCALAR_ARG_PORT_STATS_EN
  // Saturating per-transaction access counters, cleared while in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_cnt <= '0;
      st_cnt <= '0;
    end else if (state == DONE) begin
      ld_cnt <= '0;
      st_cnt <= '0;
    end else begin
      if (ld_fire && (ld_cnt != '1)) ld_cnt <= ld_cnt + CNT_WIDTH'(1);
      if (st_fire && (st_cnt != '1)) st_cnt <= st_cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign ld_cnt = '0;
  assign st_cnt = '0;
`endif

endmodule

// File: tb/tb_scalar_arg_port.sv
// Scoreboard bench for scalar_arg_port: memory model, reference word model and
// expected-response queue checked by a negedge monitor.
module tb_scalar_arg_port;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_data_valid;
  logic          ld_data_ready = 1'b0;
  logic [DW-1:0] st_data = '0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic          end_valid = 1'b0;
  logic          end_ready;
  logic          ce0;
  logic          we0;
  logic [DW-1:0] mem_din0;
  logic [DW-1:0] mem_dout0 = '0;
  logic          done;
  logic [CW-1:0] ld_cnt;
  logic [CW-1:0] st_cnt;

  scalar_arg_port dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_data_valid(ld_data_valid), .ld_data_ready(ld_data_ready),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
    .end_valid(end_valid), .end_ready(end_ready),
    .ce0(ce0), .we0(we0), .mem_din0(mem_din0), .mem_dout0(mem_dout0),
    .done(done), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef SCALAR_ARG_PORT_STATS_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  // Argument memory: one word, read data one cycle late, reloaded on done.
  logic [DW-1:0] mem_word  = 32'h0000_00A5;
  logic [DW-1:0] next_word = 32'h0BAD_F00D;
  always @(posedge clk) begin
    if (ce0 && we0)  mem_word  <= mem_din0;
    else if (ce0)    mem_dout0 <= mem_word;
    if (done) begin
      mem_word  <= next_word;
      next_word <= $urandom;
    end
  end

  // Reference model: the argument's current value, plus expected responses.
  logic [DW-1:0] model_word = 32'h0000_00A5;
  logic [DW-1:0] exp_q[$];
  logic          prev_done = 1'b0;
  int            tx_ld = 0;
  int            tx_st = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      tx_ld = 0;
      tx_st = 0;
      prev_done = 1'b0;
    end else begin
      if (st_valid) check("store_priority", 32'(ld_ready), 32'd0);
      if (st_valid && st_ready) begin
        model_word = st_data;
        tx_st++;
        check("st_ce0", 32'(ce0), 32'd1);
        check("st_we0", 32'(we0), 32'd1);
        check("st_din", mem_din0, st_data);
      end else if (ld_valid && ld_ready) begin
        exp_q.push_back(model_word);
        tx_ld++;
        check("ld_ce0", 32'(ce0), 32'd1);
        check("ld_we0", 32'(we0), 32'd0);
      end else begin
        check("idle_ce0", 32'(ce0 | we0), 32'd0);
        check("idle_din", mem_din0, 32'd0);
      end
      if (ld_data_valid && ld_data_ready) begin
        if (exp_q.size() == 0) check("unexpected_resp", ld_data, 32'hFFFF_FFFF);
        else check("ld_data", ld_data, exp_q.pop_front());
      end
      check("end_ready_eq_done", 32'(end_ready), 32'(done));
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        model_word = next_word;
        tx_ld = 0;
        tx_st = 0;
      end
      prev_done = done;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Raise end, wait (bounded) for the done pulse, then drop end.
  task automatic close_transaction(input string name);
    int waited;
    waited = 0;
    end_valid = 1'b1;
    while (!done && waited < 30) begin
      tick();
      waited++;
    end
    check(name, 32'(done), 32'd1);
    tick();
    end_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fires;
    int waited;

    // Reset values, with requests asserted to show readies are held low.
    ld_valid = 1'b1;
    st_valid = 1'b1;
    st_data  = 32'hFFFF_FFFF;
    #3;
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_st_ready", 32'(st_ready), 32'd0);
    check("rst_ce0", 32'(ce0), 32'd0);
    check("rst_we0", 32'(we0), 32'd0);
    check("rst_din", mem_din0, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_ld_data_valid", 32'(ld_data_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_end_ready", 32'(end_ready), 32'd0);
    check("rst_cnt", 32'(ld_cnt) | 32'(st_cnt), 32'd0);
    ld_valid = 1'b0;
    st_valid = 1'b0;
    st_data  = '0;
    tick(); tick();
    rst = 1'b0;
    ld_data_ready = 1'b1;

    // Single load of the initial word, latency 2.
    tick();
    ld_valid = 1'b1;
    #1 check("single_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    check("lat_n1_valid", 32'(ld_data_valid), 32'd0);
    tick();
    check("lat_n2_valid", 32'(ld_data_valid), 32'd1);
    check("lat_n2_data", ld_data, 32'h0000_00A5);

    // Store then load next cycle.
    tick();
    st_valid = 1'b1;
    st_data  = 32'h1234_5678;
    tick();
    st_valid = 1'b0;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    repeat (3) tick();

    // Same-cycle store and load: store wins, load follows.
    st_valid = 1'b1;
    ld_valid = 1'b1;
    st_data  = 32'hDEAD_BEEF;
    #1;
    check("conflict_ld_ready", 32'(ld_ready), 32'd0);
    check("conflict_st_ready", 32'(st_ready), 32'd1);
    tick();
    st_valid = 1'b0;
    #1 check("conflict_ld_next", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    repeat (3) tick();

    // Backpressure: only RESP_DEPTH loads may be outstanding.
    ld_data_ready = 1'b0;
    ld_valid = 1'b1;
    fires = 0;
    for (int c = 0; c < 6; c++) begin
      #1 if (ld_ready) fires++;
      tick();
    end
    check("bp_fires", 32'(fires), 32'd2);
    #1;
    check("bp_ld_ready", 32'(ld_ready), 32'd0);
    check("bp_buffered", 32'(ld_data_valid), 32'd1);
    ld_data_ready = 1'b1;
    waited = 0;
    while (fires < 4 && waited < 20) begin
      #1 if (ld_ready) fires++;
      tick();
      waited++;
    end
    ld_valid = 1'b0;
    check("bp_total_fires", 32'(fires), 32'd4);
    waited = 0;
    while ((ld_data_valid || exp_q.size() != 0) && waited < 20) begin
      tick();
      waited++;
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Close transaction 0 with nothing outstanding: done two cycles after end.
    check("tx0_ld_cnt", 32'(ld_cnt), exp_cnt(7));
    check("tx0_st_cnt", 32'(st_cnt), exp_cnt(2));
    end_valid = 1'b1;
    tick();
    check("end_n1_done", 32'(done), 32'd0);
    check("end_n1_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    check("end_n2_done", 32'(done), 32'd1);
    check("end_n2_end_ready", 32'(end_ready), 32'd1);
    tick();
    end_valid = 1'b0;
    check("end_n3_done", 32'(done), 32'd0);
    check("cnt_cleared", 32'(ld_cnt) | 32'(st_cnt), 32'd0);

    // End in the same cycle as a load; response held back, then drained.
    ld_data_ready = 1'b0;
    ld_valid  = 1'b1;
    end_valid = 1'b1;
    #1 check("end_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    check("inflight_ld_cnt", 32'(ld_cnt), exp_cnt(1));
    repeat (3) tick();
    check("inflight_no_done", 32'(done), 32'd0);
    check("inflight_buffered", 32'(ld_data_valid), 32'd1);
    ld_data_ready = 1'b1;
    waited = 0;
    while (!done && waited < 10) begin
      tick();
      waited++;
    end
    check("inflight_done", 32'(done), 32'd1);
    check("inflight_resp_consumed", 32'(exp_q.size()), 32'd0);
    tick();
    end_valid = 1'b0;
    check("inflight_done_low", 32'(done), 32'd0);
    check("inflight_cnt_cleared", 32'(ld_cnt), 32'd0);

    // Reset in DRAIN with one entry buffered.
    ld_data_ready = 1'b0;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick(); tick();
    check("pre_rst_buffered", 32'(ld_data_valid), 32'd1);
    end_valid = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ld_data_valid", 32'(ld_data_valid), 32'd0);
    check("mid_rst_ld_data", ld_data, 32'd0);
    check("mid_rst_readies", 32'(ld_ready) | 32'(st_ready), 32'd0);
    check("mid_rst_done", 32'(done) | 32'(end_ready), 32'd0);
    check("mid_rst_cnt", 32'(ld_cnt), 32'd0);
    end_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_ld_ready", 32'(ld_ready), 32'd1);
    check("post_rst_st_ready", 32'(st_ready), 32'd1);
    check("post_rst_empty", 32'(ld_data_valid), 32'd0);

    // Randomized transactions, each closed by an end token.
    tick();
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 80; c++) begin
        st_valid      = ($urandom_range(0, 3) == 0);
        ld_valid      = 1'($urandom_range(0, 1));
        ld_data_ready = ($urandom_range(0, 2) != 0);
        st_data       = $urandom;
        tick();
      end
      st_valid = 1'b0;
      ld_valid = 1'b0;
      ld_data_ready = 1'b1;
      #1;
      check("rand_ld_cnt", 32'(ld_cnt), exp_cnt(tx_ld));
      check("rand_st_cnt", 32'(st_cnt), exp_cnt(tx_st));
      close_transaction("rand_done");
    end

    repeat (3) tick();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scalar_arg_port.md
# scalar_arg_port

Synthesizable initiator for a scalar (single-word) kernel argument. It turns the elastic dataflow load, store and end handshakes of a generated circuit into the `ce0`/`we0`/`mem_din0`/`mem_dout0` single-port memory interface, and it generates the `done` pulse that the argument's memory model uses to close one transaction and load the next. Read data comes back one cycle after the access and is buffered so the dataflow side sees a normal valid/ready response channel.

## Interface
- `DATA_WIDTH`, 32, argument word width
- `RESP_DEPTH`, 2, load-response buffer entries (≥2); full load throughput requires ≥3
- `CNT_WIDTH`, 16, statistics counter width
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `ld_valid` / `ld_ready`  in / out  1  load request handshake
- `ld_data`  out  DATA_WIDTH  load response data
- `ld_data_valid` / `ld_data_ready`  out / in  1  load response handshake
- `st_data`  in  DATA_WIDTH  store data
- `st_valid` / `st_ready`  in / out  1  store handshake
- `end_valid` / `end_ready`  in / out  1  kernel end token
- `ce0`  out  1  memory access enable
- `we0`  out  1  memory write enable
- `mem_din0`  out  DATA_WIDTH  write data to memory
- `mem_dout0`  in  DATA_WIDTH  read data from memory
- `done`  out  1  transaction complete, one-cycle pulse
- `ld_cnt`, `st_cnt`  out  CNT_WIDTH  per-transaction access counts

## Operation
- States: RUN, DRAIN, DONE. Reset enters RUN with the buffer empty and `rd_pending`=0.
- Firing: `st_fire`=`st_valid`&`st_ready` and `ld_fire`=`ld_valid`&`ld_ready`.
- Memory outputs are combinational: `ce0`=`st_fire`|`ld_fire`, `we0`=`st_fire`, `mem_din0`=`st_data` when `st_fire`, otherwise 0.
- RUN, store path: `st_ready`=1.
- RUN, load path: `ld_ready` = !`st_valid` & (occupancy < RESP_DEPTH), where occupancy = registered buffer count + `rd_pending`.
- Store priority: a store always wins a same-cycle conflict. The load is taken the next cycle and returns the stored value.
- Load return: `ld_fire` in cycle N sets `rd_pending` for cycle N+1. At the end of N+1, `mem_dout0` is pushed into the buffer.
- RUN exit: `end_valid`=1 in RUN moves the block to DRAIN at the next edge. Loads and stores that fire in that same cycle are still accepted.
- DRAIN: `ld_ready`=`st_ready`=0. Move to DONE when `rd_pending`=0 and the buffer is empty.
- DONE, one cycle only:
  - `done`=1 (registered, state==DONE) and `end_ready`=1; the end token is consumed.
  - Counters clear.
  - Next state is RUN.
- `end_ready` is 0 in RUN and DRAIN.
- Buffer: FIFO with wrap-around pointers. `ld_data_valid` = buffer not empty; `ld_data` = head entry. A pop and a push in the same cycle keep the count unchanged. A push while full cannot happen by construction; this is asserted in simulation.
- Reset mid-operation: the in-flight read is dropped, the buffer is flushed, the state returns to RUN and the counters clear.

## Timing
- Reset values: `ce0`=0, `we0`=0, `mem_din0`=0, `ld_data`=0, `ld_data_valid`=0, `done`=0, `end_ready`=0, `ld_cnt`=`st_cnt`=0. `ld_ready`/`st_ready` are held 0 while `rst`=1.
- Load latency: `ld_fire` in N → `ld_data_valid` in N+2.
- Store-to-load: a store in N is visible to a load issued in N+1.
- `end_valid` to `done`: minimum 2 cycles (RUN→DRAIN→DONE) when nothing is outstanding. Each outstanding item adds cycles until it is drained.
- Counters: saturate at all-ones and increment on the firing edge.

## Configuration
- `SCALAR_ARG_PORT_STATS_EN` defined: `ld_cnt`/`st_cnt` count `ld_fire`/`st_fire` per transaction and clear in DONE.
- Not defined: no counter flops are built and both outputs are tied to 0.

## Structure
- Package `scalar_arg_port_pkg`:
  - state enum {RUN, DRAIN, DONE}
  - default `RESP_DEPTH`
  - pointer-width function (clog2)
- Sub-module `scalar_arg_resp_fifo`: parameterized DATA_WIDTH × RESP_DEPTH, with push, pop, count, head data and asynchronous reset.
- Top level: FSM, arbitration, `rd_pending` and counters.

## Test plan
- Single load: memory model holds 0x0000_00A5; one `ld_valid` → `ce0`=1, `we0`=0 that cycle; `ld_data`=0x0000_00A5 valid 2 cycles later.
- Store then load: `st_data`=0x1234_5678 in N and load in N+1 → `we0`=1 in N, `ld_data`=0x1234_5678.
- Simultaneous `st_valid`/`ld_valid` with `st_data`=0xDEAD_BEEF → store fires first, load fires next cycle, returns 0xDEAD_BEEF.
- Backpressure: `ld_data_ready`=0, RESP_DEPTH=2, four load requests → only two fire, `ld_ready`=0 afterwards; releasing `ld_data_ready` drains both, then the rest fire in order.
- End with a read in flight: `end_valid` in the same cycle as a load → load data still delivered; `done` is a single-cycle pulse after the buffer empties; `ld_cnt`=1 before clearing.
- Reset asserted mid-DRAIN with one entry buffered → all outputs at reset values immediately; after release, state is RUN with `ld_ready`=1.
